npc_ctrl_seq: RTL and testbench
===============================

# npc_ctrl_seq

Multi-cycle control sequencer for the NPC core. It drives the instruction-fetch handshake, latches the fetched word into an instruction register for the decoder, and steps each instruction through decode, execute, memory and write-back. It emits the one-cycle register-file and PC write strobes, and halts the core on `ebreak`, on an unsupported opcode or, optionally, on a bus timeout. It sits between the IFU/LSU bus ports and the decoder/register-file/PC datapath.

## Interface
- TIMEOUT_CYCLES, 255, wait-cycle limit in FETCH or MEM before a timeout halt (only used with the timeout macro); range 1..65535.
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  leave IDLE and begin fetching.
- ifu_req  output  1  fetch request; held high for the whole FETCH state.
- ifu_rvalid  input  1  fetch data valid; may rise in the same cycle as ifu_req.
- ifu_rdata  input  32  fetched instruction word.
- ir  output  32  latched instruction, fed to the decoder.
- lsu_req  output  1  memory access request; held high for the whole MEM state.
- lsu_wen  output  1  1 = store, 0 = load; valid while lsu_req=1.
- lsu_done  input  1  memory access complete.
- rf_wen  output  1  register-file write strobe, one cycle.
- pc_wen  output  1  PC update strobe, one cycle.
- halted  output  1  core stopped; sticky until reset.
- trap_code  output  2  halt reason: 0 none, 1 ebreak, 2 illegal, 3 timeout.
- instret  output  32  retired-instruction counter.
- state  output  3  current FSM state, for debug.

## Operation
- States, with their encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: no requests issued; moves to FETCH when start=1.
- FETCH: ifu_req=1. When ifu_rvalid=1, ir <= ifu_rdata and the FSM moves to DECODE.
- DECODE: opcode = ir[6:0], classified as follows.
  - Supported opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
  - ir == 32'h00100073 (ebreak): go to HALT, trap_code=1.
  - Any other value, including other SYSTEM encodings: go to HALT, trap_code=2.
  - Supported opcode: go to EXEC.
- EXEC: loads (0000011) and stores (0100011) go to MEM. All other supported opcodes go to WB.
- MEM: lsu_req=1, with lsu_wen=1 for stores. When lsu_done=1, go to WB.
- WB: pc_wen=1 for every instruction. rf_wen=1 except for branches (1100011) and stores. instret increments by 1 and wraps at 2^32. Next state is FETCH.
- HALT: all request and strobe outputs are 0. The FSM stays in HALT until rst_n is asserted; start has no effect.
- ifu_rvalid outside FETCH and lsu_done outside MEM are ignored.
- A halt does not increment instret; the halting instruction is not retired.

## Timing
- Reset values (async, on rst_n=0): state=IDLE, ir=0, instret=0, trap_code=0, halted=0, ifu_req=lsu_req=lsu_wen=rf_wen=pc_wen=0.
- Reset asserted mid-instruction aborts it immediately; no strobe is emitted.
- All outputs are Moore (functions of registered state and registered ir only).
- Zero-wait fetch: ALU, branch and jump instructions take 4 cycles (FETCH, DECODE, EXEC, WB); loads and stores take 5.
- Each fetch wait cycle adds 1 cycle; each memory wait cycle adds 1 cycle.
- From DECODE of ebreak, halted=1 in the next cycle.
- rf_wen and pc_wen are high for exactly one cycle per retired instruction and always coincide.

## Configuration
- NPC_BUS_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments each cycle the state waits without ifu_rvalid or lsu_done.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to HALT with trap_code=3.
  - A response arriving in the same cycle as the limit wins, and the FSM proceeds normally.
- NPC_BUS_TIMEOUT_EN undefined:
  - No counter is built; FETCH and MEM wait indefinitely.
  - trap_code never takes the value 3.

## Test plan
- Reset, start=1, zero-wait fetch of 32'h00500093 (addi): 4 cycles to the WB strobe, rf_wen=pc_wen=1 for one cycle, instret=1.
- Store 32'h00112023 with lsu_done after 3 wait cycles: lsu_req and lsu_wen held 4 cycles, pc_wen=1 and rf_wen=0 in WB, 8 cycles total.
- Fetch 32'h00100073: halted=1 and trap_code=1 two cycles after rvalid, instret unchanged; further start and rvalid are ignored.
- Fetch 32'hFFFFFFFF: HALT with trap_code=2.
- Macro defined, TIMEOUT_CYCLES=4, ifu_rvalid held 0: HALT with trap_code=3 after 4 FETCH cycles. Macro undefined: FETCH persists for 1000 cycles.
- rst_n pulsed low during MEM: all outputs return to their reset values immediately, with no rf_wen or pc_wen pulse.

Source files
------------

// File: rtl/npc_ctrl_seq.sv
// npc_ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the NPC core.
// Define NPC_BUS_TIMEOUT_EN to build the bus wait counter that halts on a stalled fetch or memory access.
module npc_ctrl_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] ir,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_done,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halted,
    output logic [1:0]  trap_code,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned TRAP_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;

    localparam logic [XLEN-1:0]   EBREAK_WORD  = 32'h0010_0073;
    localparam logic [TRAP_W-1:0] TRAP_NONE    = 2'd0;
    localparam logic [TRAP_W-1:0] TRAP_EBREAK  = 2'd1;
    localparam logic [TRAP_W-1:0] TRAP_ILLEGAL = 2'd2;
    localparam logic [TRAP_W-1:0] TRAP_TIMEOUT = 2'd3;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("npc_ctrl_seq: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_e            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [TRAP_W-1:0] trap_q, trap_d;
    logic              halted_q, halted_d;
    logic              ifu_req_q, ifu_req_d;
    logic              lsu_req_q, lsu_req_d;
    logic              lsu_wen_q, lsu_wen_d;
    logic              rf_wen_q, rf_wen_d;
    logic              pc_wen_q, pc_wen_d;

    logic [OP_W-1:0]   opcode_c;
    logic              supported_c;
    logic              is_mem_c;
    logic              is_store_c;
    logic              no_rf_write_c;
    logic              timeout_c;

    // Opcode classification of the latched instruction
    assign opcode_c      = ir_q[OP_W-1:0];
    assign is_store_c    = (opcode_c == OP_STORE);
    assign is_mem_c      = (opcode_c == OP_LOAD) || is_store_c;
    assign no_rf_write_c = (opcode_c == OP_BRANCH) || is_store_c;

    always_comb begin
        supported_c = 1'b0;
        case (opcode_c)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: supported_c = 1'b1;
            default:                           supported_c = 1'b0;
        endcase
    end

`ifdef NPC_BUS_TIMEOUT_EN
    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              waiting_c;

    // Counts stalled cycles; any cycle that is not a stall (including leaving) clears it
    assign waiting_c = ((state_q == S_FETCH) && !ifu_rvalid) || ((state_q == S_MEM) && !lsu_done);
    assign wait_d    = waiting_c ? wait_q + WAIT_W'(1) : '0;
    assign timeout_c = waiting_c && (wait_q == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Next state, instruction latch, trap reason and next registered outputs
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        trap_d    = trap_q;
        instret_d = instret_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ifu_rvalid) begin
                    ir_d    = ifu_rdata;
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    trap_d  = TRAP_TIMEOUT;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (ir_q == EBREAK_WORD) begin
                    trap_d  = TRAP_EBREAK;
                    state_d = S_HALT;
                end else if (!supported_c) begin
                    trap_d  = TRAP_ILLEGAL;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = is_mem_c ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_d = S_WB;
                end else if (timeout_c) begin
                    trap_d  = TRAP_TIMEOUT;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                instret_d = instret_q + XLEN'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered decodes of the state being entered
        ifu_req_d = (state_d == S_FETCH);
        lsu_req_d = (state_d == S_MEM);
        lsu_wen_d = (state_d == S_MEM) && is_store_c;
        pc_wen_d  = (state_d == S_WB);
        rf_wen_d  = (state_d == S_WB) && !no_rf_write_c;
        halted_d  = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            instret_q <= '0;
            trap_q    <= TRAP_NONE;
            halted_q  <= 1'b0;
            ifu_req_q <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_wen_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            pc_wen_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            halted_q  <= halted_d;
            ifu_req_q <= ifu_req_d;
            lsu_req_q <= lsu_req_d;
            lsu_wen_q <= lsu_wen_d;
            rf_wen_q  <= rf_wen_d;
            pc_wen_q  <= pc_wen_d;
        end
    end

    assign state     = state_q;
    assign ir        = ir_q;
    assign instret   = instret_q;
    assign trap_code = trap_q;
    assign halted    = halted_q;
    assign ifu_req   = ifu_req_q;
    assign lsu_req   = lsu_req_q;
    assign lsu_wen   = lsu_wen_q;
    assign rf_wen    = rf_wen_q;
    assign pc_wen    = pc_wen_q;

endmodule

// File: tb/tb_npc_ctrl_seq.sv
// tb_npc_ctrl_seq: randomized bench for npc_ctrl_seq; a per-instruction timeline model queues the
// expected outputs of every cycle and a single compare process checks them.
module tb_npc_ctrl_seq;

    localparam int unsigned TO = 4;
`ifdef NPC_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        rst_n, start, ifu_rvalid, lsu_done;
    logic [31:0] ifu_rdata;
    logic        ifu_req, lsu_req, lsu_wen, rf_wen, pc_wen, halted;
    logic [31:0] ir, instret;
    logic [1:0]  trap_code;
    logic [2:0]  state;

    npc_ctrl_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ir(ir),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_done(lsu_done),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halted(halted), .trap_code(trap_code),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        ifu_req, lsu_req, lsu_wen, rf_wen, pc_wen, halted;
        logic [1:0]  trap;
        logic [31:0] ir, instret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          n_cmp = 0, n_bad = 0, n_push = 0, lsu_cycles = 0;
    logic [31:0] m_ir, m_instret;
    logic [1:0]  m_trap;
    int          m_pre;
    logic [6:0]  ops [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    function automatic bit supported(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    endfunction

    // Compare process: one queued expectation per cycle, sampled 1 ns after the falling edge
    always @(negedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("state",     32'(state),     32'(ce.st));
            chk("ifu_req",   32'(ifu_req),   32'(ce.ifu_req));
            chk("lsu_req",   32'(lsu_req),   32'(ce.lsu_req));
            chk("lsu_wen",   32'(lsu_wen),   32'(ce.lsu_wen));
            chk("rf_wen",    32'(rf_wen),    32'(ce.rf_wen));
            chk("pc_wen",    32'(pc_wen),    32'(ce.pc_wen));
            chk("halted",    32'(halted),    32'(ce.halted));
            chk("trap_code", 32'(trap_code), 32'(ce.trap));
            chk("ir",        ir,             ce.ir);
            chk("instret",   instret,        ce.instret);
            if (lsu_req) lsu_cycles++;
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be during that cycle
    task automatic cyc(input logic s, input logic rv, input logic [31:0] rd, input logic ld,
                       input logic [2:0] st, input logic lw, input logic rf);
        exp_t e;
        @(negedge clk);
        start = s; ifu_rvalid = rv; ifu_rdata = rd; lsu_done = ld;
        e.st      = st;
        e.ifu_req = (st == S_FETCH);
        e.lsu_req = (st == S_MEM);
        e.lsu_wen = lw;
        e.rf_wen  = rf;
        e.pc_wen  = (st == S_WB);
        e.halted  = (st == S_HALT);
        e.trap    = m_trap;
        e.ir      = m_ir;
        e.instret = m_instret;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic cyc_rnd(input logic [2:0] st, input logic rf);
        cyc(1'($urandom), 1'($urandom), $urandom, 1'($urandom), st, 1'b0, rf);
    endtask

    task automatic idle_start(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), $urandom, 1'($urandom), S_IDLE, 1'b0, 1'b0);
        cyc(1'b1, 1'($urandom), $urandom, 1'($urandom), S_IDLE, 1'b0, 1'b0);
    endtask

    // One stalled FETCH cycle before the next instruction, then settle for a direct peek
    task automatic gap();
        cyc(1'($urandom), 1'b0, $urandom, 1'($urandom), S_FETCH, 1'b0, 1'b0);
        m_pre++;
        #2;
    endtask

    task automatic fetch(input logic [31:0] w, input int fw, output bit ok);
        int first;
        first = m_pre;
        m_pre = 0;
        ok = 1'b0;
        for (int i = first; i <= first + fw; i++) begin
            if (TO_EN && i == int'(TO)) begin m_trap = 2'd3; return; end
            cyc(1'($urandom), i == first + fw, (i == first + fw) ? w : $urandom, 1'($urandom),
                S_FETCH, 1'b0, 1'b0);
        end
        m_ir = w;
        ok = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, output bit retired);
        bit ok;
        logic [6:0] op;
        retired = 1'b0;
        op = w[6:0];
        fetch(w, fw, ok);
        if (!ok) return;
        cyc_rnd(S_DECODE, 1'b0);
        if (w == EBREAK)   begin m_trap = 2'd1; return; end
        if (!supported(op)) begin m_trap = 2'd2; return; end
        cyc_rnd(S_EXEC, 1'b0);
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int i = 0; i <= mw; i++) begin
                if (TO_EN && i == int'(TO)) begin m_trap = 2'd3; return; end
                cyc(1'($urandom), 1'($urandom), $urandom, i == mw, S_MEM, op == OP_STORE, 1'b0);
            end
        end
        cyc_rnd(S_WB, !(op == OP_BRANCH || op == OP_STORE));
        m_instret = m_instret + 32'd1;
        retired = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc_rnd(S_HALT, 1'b0);
    endtask

    task automatic check_reset();
        chk("rst_state",   32'(state),     32'd0);
        chk("rst_ir",      ir,             32'd0);
        chk("rst_instret", instret,        32'd0);
        chk("rst_trap",    32'(trap_code), 32'd0);
        chk("rst_halted",  32'(halted),    32'd0);
        chk("rst_ifu_req", 32'(ifu_req),   32'd0);
        chk("rst_lsu_req", 32'(lsu_req),   32'd0);
        chk("rst_lsu_wen", 32'(lsu_wen),   32'd0);
        chk("rst_rf_wen",  32'(rf_wen),    32'd0);
        chk("rst_pc_wen",  32'(pc_wen),    32'd0);
    endtask

    // Assert reset mid-cycle, confirm outputs clear at once and through a clock edge, then release
    task automatic restart(input bit in_mem);
        @(negedge clk);
        #2;
        if (in_mem) chk("pre_reset_lsu_req", 32'(lsu_req), 32'd1);
        rst_n = 1'b0; start = 1'b0; ifu_rvalid = 1'b0; lsu_done = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        m_ir = '0; m_instret = '0; m_trap = '0; m_pre = 0;
    endtask

    initial begin
        bit          r;
        int          n0, sel, fw, mw;
        logic [31:0] w;

        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
        rst_n = 1'b1; start = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0; lsu_done = 1'b0;
        m_ir = '0; m_instret = '0; m_trap = '0; m_pre = 0;
        #3 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait addi: 4 cycles, one strobe, instret becomes 1
        idle_start(2);
        n0 = n_push;
        run_instr(ADDI, 0, 0, r);
        chk("addi_cycles", 32'(n_push - n0), 32'd4);
        gap();
        chk("addi_instret", instret, 32'd1);

        // Store with three memory wait cycles
        lsu_cycles = 0;
        n0 = n_push;
        run_instr(32'h0011_2023, 0, 3, r);
        chk("store_cycles", 32'(n_push - n0), 32'd8);
        gap();
        chk("store_lsu_cycles", 32'(lsu_cycles), 32'd4);
        chk("store_instret", instret, 32'd2);

        // Randomized instruction stream with occasional halts and long stalls
        for (int k = 0; k < 160; k++) begin
            sel = int'($urandom_range(0, 19));
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 8)];
            fw = int'($urandom_range(0, 3));
            mw = int'($urandom_range(0, 3));
            if (sel == 0)      w = EBREAK;
            else if (sel == 1) w = 32'h0000_0073;
            else if (sel == 2) w[6:0] = 7'b0001111;
            else if (sel == 3) fw = 6;
            else if (sel == 4) begin w[6:0] = OP_LOAD; mw = 6; end
            run_instr(w, fw, mw, r);
            if (!r) begin
                halt_cycles(3);
                restart(1'b0);
                idle_start(int'($urandom_range(0, 2)));
            end
        end

        restart(1'b0);
        idle_start(1);
`ifdef NPC_BUS_TIMEOUT_EN
        // Response on the limit cycle wins; a longer stall halts with trap 3
        run_instr(ADDI, TO - 1, 0, r);
        gap();
        chk("limit_resp_instret", instret, 32'd1);
        run_instr(ADDI, 10, 0, r);
        halt_cycles(2);
        #2;
        chk("timeout_trap", 32'(trap_code), 32'd3);
        chk("timeout_halted", 32'(halted), 32'd1);
`else
        // Without the timeout build a fetch may stall indefinitely
        run_instr(ADDI, 1000, 0, r);
        gap();
        chk("long_fetch_instret", instret, 32'd1);
        chk("long_fetch_trap", 32'(trap_code), 32'd0);
`endif

        // ebreak after one retired instruction: halts, instret stays, inputs ignored
        restart(1'b0);
        idle_start(1);
        run_instr(ADDI, 0, 0, r);
        run_instr(EBREAK, 1, 0, r);
        halt_cycles(5);
        #2;
        chk("ebreak_trap", 32'(trap_code), 32'd1);
        chk("ebreak_halted", 32'(halted), 32'd1);
        chk("ebreak_instret", instret, 32'd1);

        // All-ones word is illegal
        restart(1'b0);
        idle_start(0);
        run_instr(32'hFFFF_FFFF, 0, 0, r);
        halt_cycles(3);
        #2;
        chk("illegal_trap", 32'(trap_code), 32'd2);

        // Reset pulsed while a load waits in MEM
        restart(1'b0);
        idle_start(0);
        fetch(32'h0000_A083, 0, r);
        cyc_rnd(S_DECODE, 1'b0);
        cyc_rnd(S_EXEC, 1'b0);
        cyc(1'b0, 1'b0, $urandom, 1'b0, S_MEM, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, $urandom, 1'b0, S_MEM, 1'b0, 1'b0);
        restart(1'b1);
        idle_start(2);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
